// File: rtl/btn_pkg.sv
// Shared definitions for the push-button input path.
//   btn_state_t   : debounce FSM state encoding
//   ms_to_cycles  : converts a millisecond interval into a number of clock
//                   cycles at a given clock frequency. The clock-divider and
//                   LED blocks can use it too.
package btn_pkg;

    // S_ prefix keeps the state names clear of the PRESSED output port.
    typedef enum logic [1:0] {
        S_RELEASED    = 2'd0,
        S_PRESS_CHK   = 2'd1,
        S_PRESSED     = 2'd2,
        S_RELEASE_CHK = 2'd3
    } btn_state_t;

    // Divide first so the default 100 MHz * 1000 ms case stays within 32 bits.
    function automatic int unsigned ms_to_cycles(input int unsigned sys_clk,
                                                 input int unsigned ms);
        return sys_clk / 1000 * ms;
    endfunction

endpackage

// File: rtl/button_debounce_sync2.sv
// Two-flop synchronizer for a single asynchronous pin.
//   clk : destination clock
//   rst : synchronous, active-high reset; both flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles behind d
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronizes the raw pin, debounces it and
// produces a clean level plus press / release / long-press strobes.
//   CLK       : system clock, all logic on posedge
//   RST       : synchronous, active-high reset
//   BTN       : raw asynchronous button pin
//   PRESSED   : debounced level, 1 while the button is accepted as pressed
//   PRESS     : one-cycle strobe when a press is accepted
//   RELEASE   : one-cycle strobe when a release is accepted
//   LONGPRESS : one-cycle strobe once the press has been held long enough
module button_debounce
    import btn_pkg::*;
#(
    parameter int unsigned SYS_CLK     = 100000000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned LONG_MS     = 1000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic PRESSED,
    output logic PRESS,
    output logic RELEASE,
    output logic LONGPRESS
);

    localparam int unsigned DB_CYCLES   = ms_to_cycles(SYS_CLK, DEBOUNCE_MS);
    localparam int unsigned LONG_CYCLES = ms_to_cycles(SYS_CLK, LONG_MS);

    generate
        if (DB_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_params
            $error("button_debounce: DB_CYCLES and LONG_CYCLES must both be >= 2");
        end
    endgenerate

    localparam int DB_W   = (DB_CYCLES   < 2) ? 1 : $clog2(DB_CYCLES);
    localparam int LONG_W = (LONG_CYCLES < 2) ? 1 : $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    // hold_cnt value whose increment lands on LONG_LAST
    localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_CYCLES - 2);

    logic              btn_s;
    logic              act;
    btn_state_t        state;
    logic [DB_W-1:0]   db_cnt;
    logic [LONG_W-1:0] hold_cnt;

    // Synchronizer resets to the released pin level so reset never looks
    // like a press.
    sync2 #(.RST_VAL(ACTIVE_LOW)) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (BTN),
        .q   (btn_s)
    );

    assign act = btn_s ^ ACTIVE_LOW;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_RELEASED;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            PRESSED   <= 1'b0;
            PRESS     <= 1'b0;
            RELEASE   <= 1'b0;
            LONGPRESS <= 1'b0;
        end else begin
            PRESS     <= 1'b0;
            RELEASE   <= 1'b0;
            LONGPRESS <= 1'b0;
            case (state)
                S_RELEASED: begin
                    if (act) begin
                        state  <= S_PRESS_CHK;
                        db_cnt <= '0;
                    end
                end
                S_PRESS_CHK: begin
                    // act reverting wins over a coincident expiry
                    if (!act) begin
                        state <= S_RELEASED;
                    end else if (db_cnt == DB_LAST) begin
                        state    <= S_PRESSED;
                        hold_cnt <= '0;
                        PRESSED  <= 1'b1;
                        PRESS    <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!act) begin
                        state  <= S_RELEASE_CHK;
                        db_cnt <= '0;
                    end
                    // Saturating counter: the strobe fires on the single
                    // increment that reaches LONG_LAST, so it cannot repeat.
                    if (hold_cnt != LONG_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (hold_cnt == LONG_PRE)
                            LONGPRESS <= 1'b1;
                    end
                end
                S_RELEASE_CHK: begin
                    // hold_cnt is frozen here so a release bounce only pauses
                    // the long-press timer instead of restarting it.
                    if (act) begin
                        state <= S_PRESSED;
                    end else if (db_cnt == DB_LAST) begin
                        state   <= S_RELEASED;
                        PRESSED <= 1'b0;
                        RELEASE <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= S_RELEASED;
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    // Strobe kinds, matching bit positions in strb
    localparam int K_PRS1 = 0;
    localparam int K_REL1 = 1;
    localparam int K_LP1  = 2;
    localparam int K_PRS0 = 3;
    localparam int K_REL0 = 4;
    localparam int K_LP0  = 5;

    logic clk;
    logic rst;
    logic btn1, btn0;
    logic pressed1, press1, release1, longpress1;
    logic pressed0, press0, release0, longpress0;
    logic [5:0] strb;

    int cyc;
    int n_chk;
    int n_fail;
    ev_t sb[$];

    button_debounce #(.SYS_CLK(1000), .DEBOUNCE_MS(10), .LONG_MS(50), .ACTIVE_LOW(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .BTN(btn1),
        .PRESSED(pressed1), .PRESS(press1), .RELEASE(release1), .LONGPRESS(longpress1)
    );

    button_debounce #(.SYS_CLK(1000), .DEBOUNCE_MS(10), .LONG_MS(50), .ACTIVE_LOW(1'b0)) dut0 (
        .CLK(clk), .RST(rst), .BTN(btn0),
        .PRESSED(pressed0), .PRESS(press0), .RELEASE(release0), .LONGPRESS(longpress0)
    );

    assign strb = {longpress0, release0, press0, longpress1, release1, press1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe seen must be the next expected event, at the
    // expected cycle.
    always @(negedge clk) begin
        ev_t e;
        for (int k = 0; k < 6; k++) begin
            if (strb[k] === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe kind=%0d at cycle %0d, none expected", k, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.kind !== k || e.cyc !== cyc) begin
                        n_fail++;
                        $display("FAIL strobe kind=%0d cycle=%0d, expected kind=%0d cycle=%0d",
                                 k, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst  = 1'b1;
        btn1 = 1'b1;
        btn0 = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({pressed1, press1, release1, longpress1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_dut1 outputs=%b expected 0000", {pressed1, press1, release1, longpress1});
        end
        n_chk++;
        if ({pressed0, press0, release0, longpress0} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_dut0 outputs=%b expected 0000", {pressed0, press0, release0, longpress0});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Release dut1 from a held press and check the level falls with RELEASE.
    task automatic release1_and_check(input string name);
        int c;
        c = cyc;
        btn1 = 1'b1;
        sb.push_back('{K_REL1, c + 13});
        repeat (12) @(negedge clk);
        n_chk++;
        if (pressed1 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_pre_release PRESSED=%b expected 1", name, pressed1);
        end
        @(negedge clk);
        n_chk++;
        if (pressed1 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release PRESSED=%b expected 0", name, pressed1);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int c;
        @(negedge clk);
        c = cyc;
        btn1 = 1'b0;
        sb.push_back('{K_PRS1, c + 13});
        sb.push_back('{K_LP1, c + 62});
        repeat (12) @(negedge clk);
        n_chk++;
        if (pressed1 !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_press_early PRESSED=%b expected 0", pressed1);
        end
        @(negedge clk);
        n_chk++;
        if (pressed1 !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_press PRESSED=%b expected 1", pressed1);
        end
        repeat (80) @(negedge clk);
        release1_and_check("clean");
    endtask

    task automatic test_bounce();
        int pat[5] = '{6, 2, 5, 20, 0};
        for (int i = 0; i < 4; i++) begin
            btn1 = (i % 2 == 0) ? 1'b0 : 1'b1;
            for (int j = 0; j < pat[i]; j++) begin
                @(negedge clk);
                n_chk++;
                if (pressed1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce PRESSED=%b expected 0 at cycle %0d", pressed1, cyc);
                end
            end
        end
    endtask

    task automatic test_release_bounce();
        int c;
        c = cyc;
        btn1 = 1'b0;
        sb.push_back('{K_PRS1, c + 13});
        // four frozen RELEASE_CHK cycles delay the long press by four
        sb.push_back('{K_LP1, c + 66});
        repeat (23) @(negedge clk);
        btn1 = 1'b1;
        repeat (4) @(negedge clk);
        btn1 = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            n_chk++;
            if (pressed1 !== 1'b1) begin
                n_fail++;
                $display("FAIL release_bounce PRESSED=%b expected 1 at cycle %0d", pressed1, cyc);
            end
        end
        repeat (30) @(negedge clk);
        release1_and_check("rel_bounce");
    endtask

    task automatic test_reset_mid_press();
        int c;
        int d;
        c = cyc;
        btn1 = 1'b0;
        sb.push_back('{K_PRS1, c + 13});
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d = cyc;
        n_chk++;
        if ({pressed1, press1, release1, longpress1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_press outputs=%b expected 0000", {pressed1, press1, release1, longpress1});
        end
        sb.push_back('{K_PRS1, d + 13});
        sb.push_back('{K_LP1, d + 62});
        repeat (12) @(negedge clk);
        n_chk++;
        if (pressed1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_redetect_early PRESSED=%b expected 0", pressed1);
        end
        @(negedge clk);
        n_chk++;
        if (pressed1 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_redetect PRESSED=%b expected 1", pressed1);
        end
        repeat (55) @(negedge clk);
        release1_and_check("reset_mid");
    endtask

    task automatic test_active_high();
        int c;
        c = cyc;
        btn0 = 1'b1;
        sb.push_back('{K_PRS0, c + 13});
        repeat (12) @(negedge clk);
        n_chk++;
        if (pressed0 !== 1'b0) begin
            n_fail++;
            $display("FAIL active_high_early PRESSED=%b expected 0", pressed0);
        end
        @(negedge clk);
        n_chk++;
        if (pressed0 !== 1'b1) begin
            n_fail++;
            $display("FAIL active_high_press PRESSED=%b expected 1", pressed0);
        end
        repeat (20) @(negedge clk);
        c = cyc;
        btn0 = 1'b0;
        sb.push_back('{K_REL0, c + 13});
        repeat (13) @(negedge clk);
        n_chk++;
        if (pressed0 !== 1'b0) begin
            n_fail++;
            $display("FAIL active_high_release PRESSED=%b expected 0", pressed0);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        ev_t e;
        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        btn1   = 1'b1;
        btn0   = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_reset_mid_press();
        test_active_high();
        repeat (10) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missed_strobe kind=%0d not seen, expected at cycle %0d", e.kind, e.cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
